// File: rtl/d_mem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store over valid/ready,
// answered after a fixed, parameterised latency from word-organised storage.
module d_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic        req_ready_reg, req_ready_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [31:0] rdata_reg;
    logic        error_reg;

    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        write_reg;

    logic        accept;
    logic        enter_resp;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_write;
    logic        acc_error;
    logic [DEPTH_LOG2-1:0] acc_index;

    logic [31:0] mem [DEPTH] = '{default: '0};

    // With LATENCY=1 the storage access happens on the accepting edge, so the
    // access operands come straight from the request port while idle.
    always_comb begin
        acc_addr  = addr_reg;
        acc_wdata = wdata_reg;
        acc_write = write_reg;
        if (state_reg == IDLE) begin
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_write = req_write;
        end
        acc_index = acc_addr[DEPTH_LOG2+1:2];
        acc_error = (acc_addr[1:0] != 2'b00) || (acc_addr[31:DEPTH_LOG2+2] != '0);
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        count_next = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        req_ready_next  = (state_next == IDLE);
        resp_valid_next = (state_next == RESP);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= IDLE;
            count_reg      <= 4'd0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            rdata_reg      <= 32'd0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            req_ready_reg  <= req_ready_next;
            resp_valid_reg <= resp_valid_next;
            if (enter_resp) begin
                error_reg <= acc_error;
                rdata_reg <= (acc_write || acc_error) ? 32'd0 : mem[acc_index];
            end
        end
    end

    // Request operands are don't-care until accepted, so they carry no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            write_reg <= req_write;
        end
    end

    // Gating on reset keeps an aborted store from committing on the reset edge.
    always_ff @(posedge clock) begin
        if (reset && enter_resp && acc_write && !acc_error) begin
            mem[acc_index] <= acc_wdata;
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = rdata_reg;
    assign resp_error = error_reg;

endmodule

// File: tb/tb_d_mem_responder.sv
// Bench for d_mem_responder: four latency builds, a per-build transaction-level
// model checked every cycle, plus directed transactions with literal expectations.
module tb_d_mem_responder;

    localparam int N = 4;
    localparam int LATS [N] = '{2, 1, 15, 4};

    logic        clock = 1'b0;
    logic        reset      [N];
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic        req_write  [N];
    logic [31:0] req_addr   [N];
    logic [31:0] req_wdata  [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [31:0] resp_rdata [N];
    logic        resp_error [N];

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;

    always #5 clock = ~clock;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            d_mem_responder #(
                .DEPTH_LOG2(8),
                .LATENCY   (LATS[gi])
            ) u_dut (
                .clock     (clock),
                .reset     (reset[gi]),
                .req_valid (req_valid[gi]),
                .req_ready (req_ready[gi]),
                .req_write (req_write[gi]),
                .req_addr  (req_addr[gi]),
                .req_wdata (req_wdata[gi]),
                .resp_valid(resp_valid[gi]),
                .resp_ready(resp_ready[gi]),
                .resp_rdata(resp_rdata[gi]),
                .resp_error(resp_error[gi])
            );
        end
    endgenerate

    // Transaction-level model: one pending transaction per build, serviced
    // LATENCY-1 edges after the accepting edge, storage as a plain word array.
    bit          m_on   [N];
    bit          m_busy [N];
    bit          m_done [N];
    int          m_ea   [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_wdata[N];
    bit          m_write[N];
    logic [31:0] m_rdata[N];
    bit          m_err  [N];
    logic [31:0] mm     [N][256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h edge=%0d", name, act, exp, edge_cnt);
        end
    endtask

    task automatic model_commit(input int k);
        m_err[k] = (m_addr[k] % 4 != 0) || (m_addr[k] >= 32'd1024);
        if (m_err[k]) begin
            m_rdata[k] = 32'd0;
        end else if (m_write[k]) begin
            mm[k][m_addr[k] / 4] = m_wdata[k];
            m_rdata[k] = 32'd0;
        end else begin
            m_rdata[k] = mm[k][m_addr[k] / 4];
        end
        m_done[k] = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            for (int w = 0; w < 256; w++) mm[k][w] = 32'd0;
            m_on[k] = 0; m_busy[k] = 0; m_done[k] = 0;
        end
        forever begin
            @(posedge clock);
            edge_cnt++;
            for (int k = 0; k < N; k++) begin
                if (!reset[k]) begin
                    m_on[k] = 1; m_busy[k] = 0; m_done[k] = 0;
                    m_rdata[k] = 32'd0; m_err[k] = 0;
                end else if (m_on[k]) begin
                    if (!m_busy[k]) begin
                        if (req_valid[k]) begin
                            m_busy[k] = 1; m_done[k] = 0; m_ea[k] = edge_cnt;
                            m_addr[k] = req_addr[k]; m_wdata[k] = req_wdata[k];
                            m_write[k] = req_write[k];
                            if (LATS[k] == 1) model_commit(k);
                        end
                    end else if (m_done[k]) begin
                        if (resp_ready[k]) m_busy[k] = 0;
                    end else if (edge_cnt == m_ea[k] + LATS[k] - 1) begin
                        model_commit(k);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            for (int k = 0; k < N; k++) begin
                if (m_on[k]) begin
                    chk($sformatf("u%0d_req_ready", k), 32'(req_ready[k]), 32'(!m_busy[k]));
                    chk($sformatf("u%0d_resp_valid", k), 32'(resp_valid[k]), 32'(m_busy[k] && m_done[k]));
                    chk($sformatf("u%0d_resp_rdata", k), resp_rdata[k], m_rdata[k]);
                    chk($sformatf("u%0d_resp_error", k), 32'(resp_error[k]), 32'(m_err[k]));
                end
            end
        end
    end

    // Issues one request and completes it; entered and left just after a rising edge.
    task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input int hold, output logic [31:0] rd, output bit er,
                       output int lat, output int ea);
        int n;
        req_valid[k] = 1; req_write[k] = w; req_addr[k] = a; req_wdata[k] = d;
        resp_ready[k] = (hold == 0);
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(posedge clock); #1; n++;
        end
        @(posedge clock); #1;
        ea = edge_cnt;
        req_valid[k] = 0; req_addr[k] = 32'hFFFF_FFFF; req_wdata[k] = ~d; req_write[k] = ~w;
        lat = 1;
        while (!resp_valid[k] && lat < 40) begin
            @(posedge clock); #1; lat++;
        end
        rd = resp_rdata[k];
        er = resp_error[k];
        if (lat >= 40) begin
            checks++; errors++;
            $display("FAIL u%0d_resp_timeout actual=no_resp expected=resp_valid", k);
            resp_ready[k] = 1;
            @(posedge clock); #1;
            resp_ready[k] = 0;
        end else begin
            for (int i = 0; i < hold; i++) begin
                req_valid[k] = 1; req_write[k] = 1; req_addr[k] = 32'h10; req_wdata[k] = 32'h0BAD0BAD;
                chk($sformatf("u%0d_bp_rdata_stable", k), resp_rdata[k], rd);
                chk($sformatf("u%0d_bp_req_ready_low", k), 32'(req_ready[k]), 32'd0);
                @(posedge clock); #1;
            end
            req_valid[k] = 0;
            resp_ready[k] = 1;
            @(posedge clock); #1;
            resp_ready[k] = 0;
        end
        $display("u%0d %s addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d accept_edge=%0d",
                 k, w ? "ST" : "LD", a, d, rd, er, lat, ea);
    endtask

    logic [31:0] rd;
    bit          er;
    int          lat, ea, prev_ea;
    bit          seen;

    initial begin
        for (int k = 0; k < N; k++) begin
            reset[k] = 0; req_valid[k] = 0; req_write[k] = 0; req_addr[k] = 0;
            req_wdata[k] = 0; resp_ready[k] = 0;
        end
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < N; k++) reset[k] = 1;

        chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst_resp_rdata", resp_rdata[0], 32'd0);
        chk("rst_resp_error", 32'(resp_error[0]), 32'd0);

        // LATENCY=2 build: store, loads, backpressure, errors
        txn(0, 1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, ea);
        chk("st10_lat", 32'(lat), 32'd2);
        chk("st10_rdata", rd, 32'd0);
        chk("st10_err", 32'(er), 32'd0);
        chk("st10_ready_after", 32'(req_ready[0]), 32'd1);
        chk("st10_valid_one_cycle", 32'(resp_valid[0]), 32'd0);
        txn(0, 0, 32'h10, 32'h0, 0, rd, er, lat, ea);
        chk("ld10_lat", 32'(lat), 32'd2);
        chk("ld10_rdata", rd, 32'hDEADBEEF);
        txn(0, 0, 32'h14, 32'h0, 0, rd, er, lat, ea);
        chk("ld14_rdata", rd, 32'h0);
        txn(0, 0, 32'h10, 32'h0, 5, rd, er, lat, ea);
        chk("bp_lat", 32'(lat), 32'd2);
        chk("bp_rdata", rd, 32'hDEADBEEF);
        chk("bp_idle_after", 32'(req_ready[0]), 32'd1);
        txn(0, 1, 32'h13, 32'h11111111, 0, rd, er, lat, ea);
        chk("st13_err", 32'(er), 32'd1);
        chk("st13_rdata", rd, 32'd0);
        txn(0, 0, 32'h10, 32'h0, 0, rd, er, lat, ea);
        chk("ld10_after_err", rd, 32'hDEADBEEF);
        txn(0, 0, 32'h400, 32'h0, 0, rd, er, lat, ea);
        chk("ld400_err", 32'(er), 32'd1);
        chk("ld400_rdata", rd, 32'd0);

        // LATENCY=1 build: back-to-back loads
        txn(1, 1, 32'h10, 32'hCAFE0001, 0, rd, er, lat, ea);
        chk("l1_st_lat", 32'(lat), 32'd1);
        prev_ea = -1;
        for (int i = 0; i < 3; i++) begin
            txn(1, 0, 32'h10, 32'h0, 0, rd, er, lat, ea);
            chk($sformatf("l1_ld%0d_lat", i), 32'(lat), 32'd1);
            chk($sformatf("l1_ld%0d_rdata", i), rd, 32'hCAFE0001);
            if (prev_ea >= 0) chk($sformatf("l1_ld%0d_interval", i), 32'(ea - prev_ea), 32'd2);
            prev_ea = ea;
        end

        // LATENCY=15 build: highest word, back-to-back loads
        txn(2, 1, 32'h3FC, 32'hA5A55A5A, 0, rd, er, lat, ea);
        chk("l15_st_lat", 32'(lat), 32'd15);
        chk("l15_st_err", 32'(er), 32'd0);
        prev_ea = -1;
        for (int i = 0; i < 2; i++) begin
            txn(2, 0, 32'h3FC, 32'h0, 0, rd, er, lat, ea);
            chk($sformatf("l15_ld%0d_lat", i), 32'(lat), 32'd15);
            chk($sformatf("l15_ld%0d_rdata", i), rd, 32'hA5A55A5A);
            if (prev_ea >= 0) chk($sformatf("l15_ld%0d_interval", i), 32'(ea - prev_ea), 32'd16);
            prev_ea = ea;
        end

        // LATENCY=4 build: reset aborts a store still waiting
        txn(3, 1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, ea);
        chk("l4_st_lat", 32'(lat), 32'd4);
        req_valid[3] = 1; req_write[3] = 1; req_addr[3] = 32'h20; req_wdata[3] = 32'h12345678;
        resp_ready[3] = 1;
        @(posedge clock); #1;
        req_valid[3] = 0;
        @(posedge clock); #1;
        reset[3] = 0;
        @(posedge clock); #1;
        reset[3] = 1;
        seen = 0;
        repeat (20) begin
            if (resp_valid[3]) seen = 1;
            @(posedge clock); #1;
        end
        resp_ready[3] = 0;
        $display("u3 ABORT ST addr=00000020 wdata=12345678 resp_seen=%0d", seen);
        chk("abort_no_resp", 32'(seen), 32'd0);
        chk("abort_ready", 32'(req_ready[3]), 32'd1);
        txn(3, 0, 32'h20, 32'h0, 0, rd, er, lat, ea);
        chk("abort_ld20_rdata", rd, 32'd0);
        txn(3, 0, 32'h10, 32'h0, 0, rd, er, lat, ea);
        chk("abort_ld10_rdata", rd, 32'hDEADBEEF);

        repeat (3) @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/d_mem_responder.md
Name: d_mem_responder

Overview:
- Multi-cycle data-memory slave: the responder end of a valid/ready request/response load/store interface driven by the processor datapath.
- Replaces the zero-latency combinational data memory when wait states are needed (multicycle/pipelined core bring-up, bus experiments).
- Word-organised storage with a programmable access latency.
- Exactly one outstanding transaction; requests are fully serialised.

Parameters:
- DEPTH_LOG2, 8: log2 of storage depth in 32-bit words (default 256 words).
- LATENCY, 2: cycles from request acceptance to first response cycle; legal range 1..15.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; word index = req_addr[DEPTH_LOG2+1:2].
- req_wdata  in  32  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts response.
- resp_rdata  out  32  load data; 0 for stores and errored accesses.
- resp_error  out  1  access was misaligned or out of range.

Behaviour:
- States:
  - IDLE: req_ready=1.
  - WAIT: latency countdown.
  - RESP: resp_valid=1.
- All outputs are registered.
- Reset (reset=0 at an edge):
  - State goes to IDLE with req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_error=0, counter=0.
  - Storage contents are not cleared. Storage initialises to all zeros at time zero.
- Acceptance: req_valid & req_ready at the edge ending cycle T.
  - Capture addr, wdata, write flag.
  - If LATENCY=1, go to RESP. Otherwise go to WAIT with counter=LATENCY-1.
  - req_ready=0 from cycle T+1 until the response handshake completes.
- WAIT: counter decrements each cycle. When counter==1, the next state is RESP.
- Response timing: resp_valid first goes high in cycle T+LATENCY.
- Memory access: storage is accessed exactly once, at the edge entering RESP.
  - Store: writes wdata.
  - Load: latches the word into resp_rdata.
- Error check: req_addr[1:0]!=0, or req_addr[31:DEPTH_LOG2+2]!=0, sets resp_error=1.
  - Storage is not written on error.
  - resp_rdata=0 on error.
- RESP:
  - resp_valid, resp_rdata and resp_error hold stable while resp_ready=0, with unlimited backpressure.
  - On resp_valid & resp_ready: go to IDLE, resp_valid=0 next cycle, req_ready=1 next cycle.
  - A new request cannot be accepted in the same cycle as a response handshake. Minimum issue interval is LATENCY+1 cycles.
- Ignored inputs:
  - req_valid is ignored while req_ready=0; no queuing.
  - Request inputs may change freely after acceptance.
- Read-after-write to the same address returns the new data, because transactions are serialised.
- Reset mid-transaction (WAIT or RESP):
  - The transaction is aborted and no response is issued.
  - A store still in WAIT is not committed.
  - A store already in RESP has already been committed.
- A stuck resp_ready=0 blocks forever; no timeout.

Test Plan:
- Reset then store: after reset=0 for 2 cycles, accept store addr 0x10, wdata 0xDEADBEEF, LATENCY=2, resp_ready=1 → resp_valid=1 exactly in cycle T+2 for one cycle, resp_error=0, resp_rdata=0, req_ready=1 at T+3.
- Load back: load addr 0x10 → resp_rdata=0xDEADBEEF at T+2. Load addr 0x14 (never written) → 0x00000000.
- Backpressure: load with resp_ready=0 for 5 cycles after resp_valid rises → outputs stable, req_valid pulses ignored (req_ready=0). resp_ready=1 → handshake, then IDLE.
- Errors:
  - Store addr 0x13 → resp_error=1; a later load of 0x10 still returns 0xDEADBEEF.
  - Load addr 0x400 with DEPTH_LOG2=8 → resp_error=1, resp_rdata=0.
- Reset abort: accept store 0x20=0x12345678 with LATENCY=4, assert reset=0 at T+2 → resp_valid never rises. Load 0x20 afterwards → 0x00000000. Earlier stores (0x10) retained.
- Latency sweep: LATENCY=1 and LATENCY=15 builds with back-to-back loads → resp_valid at T+LATENCY each time, issue interval LATENCY+1.
